// File: rtl/aclk_set_pkg.sv
// Shared types and digit helpers for the alarm-clock front-panel setting controller.
// Used by aclk_set_ctrl and aclk_btn_debounce.
package aclk_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_TIME,
    ST_EDIT_ALARM,
    ST_LOAD_TIME,
    ST_LOAD_ALARM
  } set_state_e;

  typedef enum logic [1:0] {
    SEL_H1,
    SEL_H0,
    SEL_M1,
    SEL_M0
  } sel_e;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  function automatic logic [3:0] h0_limit(input logic [1:0] h1);
    return (h1 == H1_MAX) ? H0_MAX_20 : H0_MAX;
  endfunction

  // Clamp an externally supplied time so the edit register never holds > 23:59.
  function automatic hhmm_t sanitize(input hhmm_t t);
    hhmm_t r;
    r    = t;
    r.h1 = (t.h1 > H1_MAX) ? H1_MAX : t.h1;
    r.h0 = (t.h0 > h0_limit(r.h1)) ? h0_limit(r.h1) : t.h0;
    r.m1 = (t.m1 > M1_MAX) ? M1_MAX : t.m1;
    r.m0 = (t.m0 > M0_MAX) ? M0_MAX : t.m0;
    return r;
  endfunction

  function automatic hhmm_t inc_digit(input hhmm_t t, input sel_e sel);
    hhmm_t r;
    r = t;
    case (sel)
      SEL_H1: begin
        r.h1 = (t.h1 >= H1_MAX) ? 2'd0 : t.h1 + 2'd1;
        if (r.h1 == H1_MAX && t.h0 > H0_MAX_20) r.h0 = H0_MAX_20;
      end
      SEL_H0:  r.h0 = (t.h0 >= h0_limit(t.h1)) ? 4'd0 : t.h0 + 4'd1;
      SEL_M1:  r.m1 = (t.m1 >= M1_MAX) ? 4'd0 : t.m1 + 4'd1;
      default: r.m0 = (t.m0 >= M0_MAX) ? 4'd0 : t.m0 + 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aclk_set_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debounce, and a
// one-cycle pulse on each accepted press (release produces nothing).
module aclk_btn_debounce
  import aclk_set_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/aclk_set_ctrl.sv
// Front-panel time/alarm setting controller feeding the alarm clock core's load port.
// Optional `AUTO_REPEAT_EN: held inc button fires an extra increment every REPEAT_CYCLES.
module aclk_set_ctrl
  import aclk_set_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned LD_HOLD        = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned REPEAT_CYCLES  = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] edit_sel
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW = $clog2(LD_HOLD + 1);

  logic mode_level, mode_evt;
  logic next_level, next_evt;
  logic inc_level, inc_press, inc_evt;

  aclk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_mode), .level_o(mode_level), .press_o(mode_evt)
  );
  aclk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_next), .level_o(next_level), .press_o(next_evt)
  );
  aclk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_inc), .level_o(inc_level), .press_o(inc_press)
  );

  set_state_e    state_q;
  hhmm_t         edit_q, alarm_q;
  sel_e          sel_q;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] ld_cnt_q;
  logic          ld_time_q, ld_alarm_q, editing_q;
  logic          unused_lvl;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_q;
  logic          rep_fire;

  assign rep_fire = inc_level && !inc_press && editing_q && (rep_q == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_q <= '0;
    end else if (!inc_level || !editing_q || inc_press || rep_fire) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end

  assign inc_evt    = inc_press | rep_fire;
  assign unused_lvl = ^{mode_level, next_level};
`else
  assign inc_evt    = inc_press;
  assign unused_lvl = ^{mode_level, next_level, inc_level, (REPEAT_CYCLES == 0)};
`endif

  // Priority mode > next > inc: lower-priority events in the same cycle are dropped.
  logic do_next, do_inc;
  assign do_next = next_evt & ~mode_evt;
  assign do_inc  = inc_evt & ~mode_evt & ~next_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      edit_q     <= '0;
      alarm_q    <= '0;
      sel_q      <= SEL_H1;
      tmo_q      <= '0;
      ld_cnt_q   <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      editing_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mode_evt) begin
            state_q   <= ST_EDIT_TIME;
            editing_q <= 1'b1;
            edit_q    <= sanitize(hhmm_t'{cur_h1, cur_h0, cur_m1, cur_m0});
            sel_q     <= SEL_H1;
            tmo_q     <= '0;
          end
        end
        ST_EDIT_TIME, ST_EDIT_ALARM: begin
          if (mode_evt) begin
            if (state_q == ST_EDIT_TIME) begin
              state_q <= ST_EDIT_ALARM;
              edit_q  <= alarm_q;
              sel_q   <= SEL_H1;
              tmo_q   <= '0;
            end else begin
              state_q   <= ST_IDLE;
              editing_q <= 1'b0;
            end
          end else if (do_next) begin
            tmo_q <= '0;
            if (sel_q == SEL_M0) begin
              editing_q <= 1'b0;
              ld_cnt_q  <= LW'(LD_HOLD - 1);
              if (state_q == ST_EDIT_TIME) begin
                state_q   <= ST_LOAD_TIME;
                ld_time_q <= 1'b1;
              end else begin
                state_q    <= ST_LOAD_ALARM;
                ld_alarm_q <= 1'b1;
                alarm_q    <= edit_q;
              end
            end else begin
              sel_q <= sel_e'(sel_q + 2'd1);
            end
          end else if (do_inc) begin
            edit_q <= inc_digit(edit_q, sel_q);
            tmo_q  <= '0;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ST_IDLE;
            editing_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_LOAD_TIME, ST_LOAD_ALARM: begin
          if (ld_cnt_q == '0) begin
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            ld_cnt_q <= ld_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          editing_q  <= 1'b0;
          ld_time_q  <= 1'b0;
          ld_alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign H_in1    = edit_q.h1;
  assign H_in0    = edit_q.h0;
  assign M_in1    = edit_q.m1;
  assign M_in0    = edit_q.m0;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign editing  = editing_q;
  assign edit_sel = sel_q;

endmodule

// File: tb/tb_aclk_set_ctrl.sv
// Directed self-checking bench for aclk_set_ctrl (default build, auto-repeat off).
module tb_aclk_set_ctrl;

  localparam int unsigned LD_HOLD_TB = 24;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode, btn_next, btn_inc;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing;
  logic [1:0] edit_sel;

  int n_checks = 0;
  int n_errors = 0;
  int lt_cyc = 0, la_cyc = 0, lt_rise = 0, la_rise = 0, both_cyc = 0;
  logic lt_prev = 1'b0, la_prev = 1'b0;
  int lt0, la0, ltr0, lar0;

  aclk_set_ctrl #(
    .DEB_CYCLES(4), .LD_HOLD(LD_HOLD_TB), .TIMEOUT_CYCLES(1000), .REPEAT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .edit_sel(edit_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (LD_time) lt_cyc++;
    if (LD_alarm) la_cyc++;
    if (LD_time && LD_alarm) both_cyc++;
    if (LD_time && !lt_prev) lt_rise++;
    if (LD_alarm && !la_prev) la_rise++;
    lt_prev = LD_time;
    la_prev = LD_alarm;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_hhmm(input string tag, input logic [1:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
    check(tag, {18'd0, H_in1, H_in0, M_in1, M_in0}, {18'd0, h1, h0, m1, m0});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = mode, 1 = next, 2 = inc
  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: btn_mode = 1'b1;
        1: btn_next = 1'b1;
        default: btn_inc = 1'b1;
      endcase
      cyc(10);
      btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      cyc(10);
    end
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0;
  endtask

  task automatic snap;
    lt0 = lt_cyc; la0 = la_cyc; ltr0 = lt_rise; lar0 = la_rise;
  endtask

  initial begin
    reset_n = 1'b0;
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    set_cur(2'd1, 4'd2, 4'd3, 4'd4);
    cyc(3);
    check_hhmm("reset_digits", 0, 0, 0, 0);
    check("reset_ld_time", LD_time, 0);
    check("reset_ld_alarm", LD_alarm, 0);
    check("reset_editing", editing, 0);
    check("reset_edit_sel", edit_sel, 0);
    reset_n = 1'b1;
    cyc(3);

    press(0, 1);
    check("enter_editing", editing, 1);
    check_hhmm("enter_seed_1234", 1, 2, 3, 4);
    check("enter_sel", edit_sel, 0);
    press(0, 1);
    check_hhmm("alarm_shadow_reset", 0, 0, 0, 0);
    check("alarm_edit_editing", editing, 1);
    press(0, 1);
    check("alarm_abort_idle", editing, 0);

    // Time set 21:07
    set_cur(2'd0, 4'd0, 4'd0, 4'd0);
    press(0, 1);
    press(2, 2);
    check_hhmm("time_h1_2", 2, 0, 0, 0);
    press(1, 1);
    press(2, 1);
    check_hhmm("time_h0_1", 2, 1, 0, 0);
    press(1, 2);
    press(2, 7);
    check_hhmm("time_m0_7", 2, 1, 0, 7);
    check("time_sel_m0", edit_sel, 3);
    snap();
    press(1, 1);
    cyc(30);
    check("time_ld_len", lt_cyc - lt0, LD_HOLD_TB);
    check("time_ld_pulses", lt_rise - ltr0, 1);
    check("time_no_ld_alarm", la_cyc - la0, 0);
    check("time_idle_after", editing, 0);
    check_hhmm("time_hold_2107", 2, 1, 0, 7);

    // Hour clamp from 19:00
    set_cur(2'd1, 4'd9, 4'd0, 4'd0);
    press(0, 1);
    press(2, 1);
    check_hhmm("clamp_h0_3", 2, 3, 0, 0);
    press(1, 1);
    press(2, 1);
    check_hhmm("h0_wrap_0", 2, 0, 0, 0);
    press(2, 3);
    check_hhmm("h0_back_3", 2, 3, 0, 0);
    press(1, 1);
    press(2, 5);
    check_hhmm("m1_at_5", 2, 3, 5, 0);
    press(2, 1);
    check_hhmm("m1_wrap_0", 2, 3, 0, 0);
    press(0, 2);

    // Alarm set 06:30
    press(0, 2);
    check_hhmm("alarm_seed_0000", 0, 0, 0, 0);
    press(1, 1);
    press(2, 6);
    press(1, 1);
    press(2, 3);
    press(1, 1);
    check_hhmm("alarm_0630", 0, 6, 3, 0);
    snap();
    press(1, 1);
    cyc(30);
    check("alarm_ld_len", la_cyc - la0, LD_HOLD_TB);
    check("alarm_ld_pulses", la_rise - lar0, 1);
    check("alarm_no_ld_time", lt_cyc - lt0, 0);
    check("no_overlap", both_cyc, 0);
    press(0, 2);
    check_hhmm("alarm_reseed_0630", 0, 6, 3, 0);
    check("alarm_reseed_sel", edit_sel, 0);
    press(0, 1);

    // Timeout
    set_cur(2'd1, 4'd2, 4'd3, 4'd4);
    snap();
    press(0, 1);
    press(2, 1);
    check_hhmm("tmo_edit_2234", 2, 2, 3, 4);
    cyc(900);
    check("tmo_still_editing", editing, 1);
    cyc(150);
    check("tmo_expired", editing, 0);
    check("tmo_no_ld_time", lt_cyc - lt0, 0);
    check("tmo_no_ld_alarm", la_cyc - la0, 0);

    // Mode and next together: only mode acts
    press(0, 1);
    press(1, 2);
    check("pre_simul_sel", edit_sel, 2);
    btn_mode = 1'b1; btn_next = 1'b1;
    cyc(10);
    btn_mode = 1'b0; btn_next = 1'b0;
    cyc(10);
    check("simul_editing", editing, 1);
    check("simul_sel", edit_sel, 0);
    check_hhmm("simul_alarm_seed", 0, 6, 3, 0);
    press(0, 1);

    // Bounce rejection
    press(0, 1);
    check_hhmm("bounce_seed", 1, 2, 3, 4);
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1; cyc(1);
      btn_inc = 1'b0; cyc(3);
    end
    btn_inc = 1'b1; cyc(3);
    btn_inc = 1'b0; cyc(10);
    check_hhmm("bounce_no_inc", 1, 2, 3, 4);
    press(2, 1);
    check_hhmm("bounce_real_inc", 2, 2, 3, 4);

    // Reset in the middle of LOAD_TIME
    press(1, 3);
    check("pre_load_sel", edit_sel, 3);
    snap();
    btn_next = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (LD_time) break;
      cyc(1);
    end
    check("midload_ld_rose", LD_time, 1);
    cyc(LD_HOLD_TB / 2);
    reset_n = 1'b0;
    #2;
    check("midload_ld_drop", LD_time, 0);
    check("midload_editing", editing, 0);
    check_hhmm("midload_digits", 0, 0, 0, 0);
    btn_next = 1'b0;
    cyc(5);
    reset_n = 1'b1;
    cyc(40);
    check("midload_no_retry", LD_time, 0);
    check("midload_one_pulse", lt_rise - ltr0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
